cpu8_exec_ctrl: RTL and testbench

//  Instruction sequencer and register file feeding the 8-bit ALU.

---
 rtl/cpu8_pkg.sv | 32 +++
 rtl/cpu8_regfile.sv | 53 +++++
 rtl/cpu8_exec_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cpu8_exec_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared constants and types for the cpu8 execution controller.
//   DATA_W, NUM_REGS : datapath width and register count
//   MODE_BIT         : bit index of the mode field in an instruction byte
//   op_e             : ALU op codes (also the instruction op field)
//   state_e          : sequencer states
package cpu8_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned MODE_BIT = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    IMM,
    HALT
  } state_e;

endpackage

// File: rtl/cpu8_regfile.sv
// cpu8_regfile: NUM_REGS x DATA_W register file, synchronous reset to 0.
//   clk, rst        : clock, synchronous active-high reset
//   ra_a/rd_a       : async read port A
//   ra_b/rd_b       : async read port B
//   we/wa/wd        : synchronous write port
//   dbg_sel/dbg_data: extra async read port, only with CPU8_DBG_PORT_EN
module cpu8_regfile
  import cpu8_pkg::*;
#(
  parameter int unsigned DATA_W   = cpu8_pkg::DATA_W,
  parameter int unsigned NUM_REGS = cpu8_pkg::NUM_REGS,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra_a,
  output logic [DATA_W-1:0] rd_a,
  input  logic [AW-1:0]     ra_b,
  output logic [DATA_W-1:0] rd_b,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
`ifdef CPU8_DBG_PORT_EN
  ,
  input  logic [AW-1:0]     dbg_sel,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_a = regs_q[ra_a];
  assign rd_b = regs_q[ra_b];

`ifdef CPU8_DBG_PORT_EN
  assign dbg_data = regs_q[dbg_sel];
`endif

endmodule

// File: rtl/cpu8_exec_ctrl.sv
// cpu8_exec_ctrl: instruction sequencer + register file driving an external ALU.
//   clk, rst                 : clock, synchronous active-high reset
//   instr_data/valid/ready   : byte stream of instructions and LDI immediates
//   alu_a/alu_b/alu_sel      : registered ALU operands and op select
//   alu_result/alu_carry     : ALU outputs, captured in WB
//   carry_flag/zero_flag     : flags from the last writeback
//   halted                   : high while in HALT (left only by rst)
//   dbg_sel/dbg_data         : register read port, only with CPU8_DBG_PORT_EN
// Instruction byte: [7:5] op, [4] mode, [3:2] rd, [1:0] rs.
module cpu8_exec_ctrl
  import cpu8_pkg::*;
#(
  parameter int unsigned DATA_W       = cpu8_pkg::DATA_W,
  parameter int unsigned NUM_REGS     = cpu8_pkg::NUM_REGS,
  parameter bit          HALT_ON_DIV0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        instr_data,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              halted
`ifdef CPU8_DBG_PORT_EN
  ,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  state_e            state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_sel_q, alu_sel_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;

  op_e               op;
  logic              mode;
  logic [1:0]        rd, rs;
  logic [DATA_W-1:0] rd_data, rs_data;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wd;

  assign op   = op_e'(instr_q[7:5]);
  assign mode = instr_q[MODE_BIT];
  assign rd   = instr_q[3:2];
  assign rs   = instr_q[1:0];

  cpu8_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_a     (rd),
    .rd_a     (rd_data),
    .ra_b     (rs),
    .rd_b     (rs_data),
    .we       (rf_we),
    .wa       (rd),
    .wd       (rf_wd)
`ifdef CPU8_DBG_PORT_EN
    ,
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
`endif
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    rf_we       = 1'b0;
    rf_wd       = '0;
    instr_ready = 1'b0;

    unique case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr_data;
          state_d = DECODE;
        end
      end

      DECODE: begin
        if (mode) begin
          if (op == OP_ADD) begin
            state_d = IMM;
          end else if (op == OP_CMP) begin
            state_d = HALT;
          end else begin
            rf_we   = 1'b1;
            rf_wd   = rs_data;
            zero_d  = (rs_data == '0);
            state_d = FETCH;
          end
        end else begin
          // ~op for one cycle ahead of op guarantees the select toggles
          // even for back-to-back identical ops.
          alu_a_d   = rd_data;
          alu_b_d   = rs_data;
          alu_sel_d = ~op;
          state_d   = EXEC;
        end
      end

      EXEC: begin
        alu_sel_d = op;
        state_d   = WB;
      end

      WB: begin
        rf_we   = 1'b1;
        carry_d = alu_carry;
        if (op == OP_DIV && alu_carry) begin
          rf_wd   = '0;
          zero_d  = 1'b1;
          state_d = HALT_ON_DIV0 ? HALT : FETCH;
        end else begin
          rf_wd   = alu_result;
          zero_d  = (alu_result == '0);
          state_d = FETCH;
        end
      end

      IMM: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          rf_we   = 1'b1;
          rf_wd   = instr_data;
          zero_d  = (instr_data == '0);
          state_d = FETCH;
        end
      end

      HALT: state_d = HALT;

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_cpu8_exec_ctrl.sv
// tb_cpu8_exec_ctrl: directed bench for cpu8_exec_ctrl with a behavioural ALU.
// Optional register read-back through the debug port when CPU8_DBG_PORT_EN is defined.
module tb_cpu8_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr_data = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       alu_carry;
  logic       carry_flag, zero_flag, halted;
`ifdef CPU8_DBG_PORT_EN
  logic [1:0] dbg_sel = '0;
  logic [7:0] dbg_data;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  cpu8_exec_ctrl #(
    .DATA_W       (8),
    .NUM_REGS     (4),
    .HALT_ON_DIV0 (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .halted      (halted)
`ifdef CPU8_DBG_PORT_EN
    ,
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: carry is carry-out for add, borrow for sub/cmp,
  // high-byte-nonzero for mul, divisor-zero for div.
  logic [15:0] prod;
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    prod       = alu_a * alu_b;
    case (alu_sel)
      3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: begin alu_result = prod[7:0]; alu_carry = |prod[15:8]; end
      3'd6: begin
        if (alu_b == '0) alu_carry = 1'b1;
        else             alu_result = alu_a / alu_b;
      end
      default: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [2:0] op, input logic m,
                                     input logic [1:0] rd, input logic [1:0] rs);
    return {op, m, rd, rs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte until accepted; returns just after the handshake edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    instr_data  = b;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      tick();
      n++;
    end
    if (!instr_ready) check("handshake_timeout", {31'd0, instr_ready}, 32'd1);
    else              tick();
    instr_valid = 1'b0;
  endtask

  task automatic ldi(input logic [1:0] rd, input logic [7:0] v);
    send(enc(3'd0, 1'b1, rd, 2'd0));
    send(v);
  endtask

  // Issue an ALU op; report operands/select seen in EXEC and WB and the
  // number of edges from the handshake until instr_ready returns.
  task automatic exec_alu(input logic [7:0] ins, output logic [7:0] a, output logic [7:0] b,
                          output logic [2:0] s1, output logic [2:0] s2, output int lat);
    send(ins);
    tick();
    a  = alu_a;
    b  = alu_b;
    s1 = alu_sel;
    tick();
    s2  = alu_sel;
    lat = 2;
    while (!instr_ready && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Read a register through OR rd,rd (value appears on alu_a; clobbers flags).
  task automatic peek(input logic [1:0] r, output logic [7:0] v);
    logic [7:0] b;
    logic [2:0] s1, s2;
    int lat;
    exec_alu(enc(3'd3, 1'b0, r, r), v, b, s1, s2, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    check({tag, "_alu_a"}, {24'd0, alu_a}, 32'd0);
    check({tag, "_alu_b"}, {24'd0, alu_b}, 32'd0);
    check({tag, "_alu_sel"}, {29'd0, alu_sel}, 32'd0);
    check({tag, "_carry"}, {31'd0, carry_flag}, 32'd0);
    check({tag, "_zero"}, {31'd0, zero_flag}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  initial begin
    logic [7:0] a, b, v;
    logic [2:0] s1, s2;
    int lat, hits;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("rst0");

    // 1: 5 + 3
    ldi(2'd0, 8'h05);
    ldi(2'd1, 8'h03);
    check("ldi3_zero", {31'd0, zero_flag}, 32'd0);
    exec_alu(enc(3'd0, 1'b0, 2'd0, 2'd1), a, b, s1, s2, lat);
    check("add1_a", {24'd0, a}, 32'h05);
    check("add1_b", {24'd0, b}, 32'h03);
    check("add1_sel_pre", {29'd0, s1}, 32'd7);
    check("add1_sel_op", {29'd0, s2}, 32'd0);
    check("add1_latency", lat, 3);
    check("add1_carry", {31'd0, carry_flag}, 32'd0);
    check("add1_zero", {31'd0, zero_flag}, 32'd0);
    peek(2'd0, v);
    check("add1_r0", {24'd0, v}, 32'h08);

    // 2: 0xFF + 0x01 wraps
    ldi(2'd0, 8'hFF);
    ldi(2'd1, 8'h01);
    exec_alu(enc(3'd0, 1'b0, 2'd0, 2'd1), a, b, s1, s2, lat);
    check("add2_a", {24'd0, a}, 32'hFF);
    check("add2_carry", {31'd0, carry_flag}, 32'd1);
    check("add2_zero", {31'd0, zero_flag}, 32'd1);
    peek(2'd0, v);
    check("add2_r0", {24'd0, v}, 32'h00);

    // 3: back-to-back XOR R2,R2 (rd==rs)
    ldi(2'd2, 8'h5A);
    exec_alu(enc(3'd4, 1'b0, 2'd2, 2'd2), a, b, s1, s2, lat);
    check("xor1_a", {24'd0, a}, 32'h5A);
    check("xor1_b", {24'd0, b}, 32'h5A);
    check("xor1_sel_pre", {29'd0, s1}, 32'd3);
    check("xor1_sel_op", {29'd0, s2}, 32'd4);
    check("xor1_zero", {31'd0, zero_flag}, 32'd1);
    exec_alu(enc(3'd4, 1'b0, 2'd2, 2'd2), a, b, s1, s2, lat);
    check("xor2_a", {24'd0, a}, 32'h00);
    check("xor2_sel_pre", {29'd0, s1}, 32'd3);
    check("xor2_sel_op", {29'd0, s2}, 32'd4);
    check("xor2_zero", {31'd0, zero_flag}, 32'd1);
    check("xor2_carry", {31'd0, carry_flag}, 32'd0);

    // 6: LDI with stalled immediate; carry must hold
    ldi(2'd0, 8'hFF);
    ldi(2'd1, 8'h01);
    exec_alu(enc(3'd0, 1'b0, 2'd0, 2'd1), a, b, s1, s2, lat);
    check("pre6_carry", {31'd0, carry_flag}, 32'd1);
    send(enc(3'd0, 1'b1, 2'd2, 2'd0));
    tick();
    hits = 0;
    repeat (5) begin
      if (instr_ready) hits++;
      tick();
    end
    check("imm_wait_ready", hits, 5);
    send(8'hA5);
    check("ldi6_carry", {31'd0, carry_flag}, 32'd1);
    check("ldi6_zero", {31'd0, zero_flag}, 32'd0);
`ifdef CPU8_DBG_PORT_EN
    dbg_sel = 2'd2;
    #1;
    check("dbg_r2", {24'd0, dbg_data}, 32'hA5);
`endif
    // MOV R3,R2 writes in DECODE and returns to FETCH after one edge
    send(enc(3'd1, 1'b1, 2'd3, 2'd2));
    lat = 0;
    while (!instr_ready && lat < 20) begin
      tick();
      lat++;
    end
    check("mov_latency", lat, 1);
    check("mov_carry", {31'd0, carry_flag}, 32'd1);
    check("mov_zero", {31'd0, zero_flag}, 32'd0);
    peek(2'd3, v);
    check("mov_r3", {24'd0, v}, 32'hA5);
    peek(2'd2, v);
    check("ldi6_r2", {24'd0, v}, 32'hA5);

    // 5: reset during EXEC of SUB R3,R0
    ldi(2'd0, 8'h07);
    send(enc(3'd1, 1'b0, 2'd3, 2'd0));
    tick();
    check("sub_exec_sel", {29'd0, alu_sel}, 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    peek(2'd3, v);
    check("rst_mid_r3", {24'd0, v}, 32'h00);

    // Reset while an LDI immediate is pending drops the byte
    send(enc(3'd0, 1'b1, 2'd1, 2'd0));
    tick();
    instr_data  = 8'h77;
    instr_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_valid = 1'b0;
    check("rst_imm_ready", {31'd0, instr_ready}, 32'd1);
    peek(2'd1, v);
    check("rst_imm_r1", {24'd0, v}, 32'h00);

    // 4: divide by zero halts
    ldi(2'd0, 8'h42);
    ldi(2'd1, 8'h00);
    check("ldi0_zero", {31'd0, zero_flag}, 32'd1);
    send(enc(3'd6, 1'b0, 2'd0, 2'd1));
    tick();
    check("div_a", {24'd0, alu_a}, 32'h42);
    check("div_sel_pre", {29'd0, alu_sel}, 32'd1);
    tick();
    check("div_sel_op", {29'd0, alu_sel}, 32'd6);
    tick();
    check("div_halted", {31'd0, halted}, 32'd1);
    check("div_carry", {31'd0, carry_flag}, 32'd1);
    check("div_zero", {31'd0, zero_flag}, 32'd1);
`ifdef CPU8_DBG_PORT_EN
    dbg_sel = 2'd0;
    #1;
    check("div_r0", {24'd0, dbg_data}, 32'h00);
`endif
    instr_data  = 8'h10;
    instr_valid = 1'b1;
    hits = 0;
    repeat (20) begin
      if (instr_ready) hits++;
      tick();
    end
    instr_valid = 1'b0;
    check("halt_ready_low", hits, 0);
    check("halt_stays", {31'd0, halted}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_halt");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
